// File: rtl/fp_cvt_sched.sv
// fp_cvt_sched: shares one fp_cvt datapath and its fp_rnd rounder between NREQ requesters.
// Round-robin arbitration accepts at most one job per cycle; the job is held one cycle in an
// issue register that drives the combinational fp_cvt inputs. f2f/i2f jobs launch into the
// rounder, f2i results ride a matched-delay pipe, and every completion lands in order in a
// response FIFO. A credit counter (issue reg + pipe + FIFO) prevents FIFO overflow.
// Ports:
//   reset, clock        asynchronous active-low reset, clock
//   flush               discard all in-flight and queued jobs
//   req_*               per-requester job handshake and payload (packed, requester 0 in LSBs)
//   cvt_*               shared fp_cvt inputs (zero when idle)
//   f2i_result/flags    combinational fp_cvt f2i outputs
//   rnd_valid/sel       rounder launch and input-bundle select
//   rnd_result/flags    rounder outputs, RND_LAT cycles after rnd_valid
//   resp_*              in-order response stream (valid/ready)
//   busy                any job in issue reg, pipe or FIFO
module fp_cvt_sched #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned TAGW       = 4,
    parameter int unsigned RND_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    reset,
    input  logic                    clock,
    input  logic                    flush,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_kind,
    input  logic [65*NREQ-1:0]      req_data,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [2*NREQ-1:0]       req_fmt,
    input  logic [3*NREQ-1:0]       req_rm,
    input  logic [10*NREQ-1:0]      req_class,
    input  logic [TAGW*NREQ-1:0]    req_tag,
    output logic [64:0]             cvt_data,
    output logic [1:0]              cvt_op,
    output logic [1:0]              cvt_fmt,
    output logic [2:0]              cvt_rm,
    output logic [9:0]              cvt_class,
    input  logic [63:0]             f2i_result,
    input  logic [4:0]              f2i_flags,
    output logic                    rnd_valid,
    output logic                    rnd_sel,
    input  logic [63:0]             rnd_result,
    input  logic [4:0]              rnd_flags,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [63:0]             resp_result,
    output logic [4:0]              resp_flags,
    output logic [$clog2(NREQ)-1:0] resp_src,
    output logic [TAGW-1:0]         resp_tag,
    output logic                    busy
);
    localparam int unsigned SW   = $clog2(NREQ);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAST = RND_LAT - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic            grant;
    logic [SW-1:0]   win, ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pop, push, fifo_full, fifo_empty;
    logic [63:0]     push_res;
    logic [4:0]      push_flg;

    // Selected job payload, zero when nothing is granted so the issue reg idles at zero.
    logic [1:0]      sel_kind, iss_kind_q;
    logic [64:0]     sel_data, iss_data_q;
    logic [1:0]      sel_op, iss_op_q, sel_fmt, iss_fmt_q;
    logic [2:0]      sel_rm, iss_rm_q;
    logic [9:0]      sel_class, iss_class_q;
    logic [TAGW-1:0] sel_tag, iss_tag_q;
    logic [SW-1:0]   iss_src_q;
    logic            iss_valid_q;

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant     = 1'b0;
        win       = '0;
        req_ready = '0;
        if (reset && !flush && (cnt_q < DEPTH_C)) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                if (!grant && req_valid[(int'(ptr_q) + k) % int'(NREQ)]) begin
                    grant = 1'b1;
                    win   = SW'((int'(ptr_q) + k) % int'(NREQ));
                end
            end
        end
        req_ready[win] = grant;
        sel_kind  = '0;
        sel_data  = '0;
        sel_op    = '0;
        sel_fmt   = '0;
        sel_rm    = '0;
        sel_class = '0;
        sel_tag   = '0;
        if (grant) begin
            sel_kind  = req_kind[2*int'(win) +: 2];
            sel_data  = req_data[65*int'(win) +: 65];
            sel_op    = req_op[2*int'(win) +: 2];
            sel_fmt   = req_fmt[2*int'(win) +: 2];
            sel_rm    = req_rm[3*int'(win) +: 3];
            sel_class = req_class[10*int'(win) +: 10];
            sel_tag   = req_tag[TAGW*int'(win) +: TAGW];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q       <= SW'(NREQ - 1);
            iss_valid_q <= 1'b0;
            iss_kind_q  <= '0;
            iss_data_q  <= '0;
            iss_op_q    <= '0;
            iss_fmt_q   <= '0;
            iss_rm_q    <= '0;
            iss_class_q <= '0;
            iss_tag_q   <= '0;
            iss_src_q   <= '0;
        end else begin
            if (grant) ptr_q <= win;
            iss_valid_q <= grant;
            iss_kind_q  <= sel_kind;
            iss_data_q  <= sel_data;
            iss_op_q    <= sel_op;
            iss_fmt_q   <= sel_fmt;
            iss_rm_q    <= sel_rm;
            iss_class_q <= sel_class;
            iss_tag_q   <= sel_tag;
            iss_src_q   <= win;
        end
    end

    assign cvt_data  = iss_data_q;
    assign cvt_op    = iss_op_q;
    assign cvt_fmt   = iss_fmt_q;
    assign cvt_rm    = iss_rm_q;
    assign cvt_class = iss_class_q;
    // kind 0 (f2f) and 2 (i2f) are the even kinds; kind[1] picks the i2f bundle.
    assign rnd_valid = iss_valid_q && !iss_kind_q[0] && !flush;
    assign rnd_sel   = iss_kind_q[1];

    // Matched-delay pipe alongside the rounder.
    logic [RND_LAT-1:0] pv_q;
    logic [1:0]         pk_q [RND_LAT];
    logic [SW-1:0]      ps_q [RND_LAT];
    logic [TAGW-1:0]    pt_q [RND_LAT];
    logic [63:0]        pr_q [RND_LAT];
    logic [4:0]         pf_q [RND_LAT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pv_q <= '0;
            for (int s = 0; s < int'(RND_LAT); s++) begin
                pk_q[s] <= '0;
                ps_q[s] <= '0;
                pt_q[s] <= '0;
                pr_q[s] <= '0;
                pf_q[s] <= '0;
            end
        end else begin
            for (int s = int'(RND_LAT) - 1; s > 0; s--) begin
                pv_q[s] <= pv_q[s-1] && !flush;
                pk_q[s] <= pk_q[s-1];
                ps_q[s] <= ps_q[s-1];
                pt_q[s] <= pt_q[s-1];
                pr_q[s] <= pr_q[s-1];
                pf_q[s] <= pf_q[s-1];
            end
            pv_q[0] <= iss_valid_q && !flush;
            pk_q[0] <= iss_kind_q;
            ps_q[0] <= iss_src_q;
            pt_q[0] <= iss_tag_q;
            pr_q[0] <= (iss_kind_q == 2'd1) ? f2i_result : '0;
            pf_q[0] <= (iss_kind_q == 2'd1) ? f2i_flags : '0;
        end
    end

    assign push     = pv_q[LAST] && !flush;
    assign push_res = pk_q[LAST][0] ? pr_q[LAST] : rnd_result;
    assign push_flg = pk_q[LAST][0] ? pf_q[LAST] : rnd_flags;

    // Response FIFO; pointers carry an extra wrap bit to tell full from empty.
    logic [AW:0]     wr_q, rd_q;
    logic [63:0]     fr_q [FIFO_DEPTH];
    logic [4:0]      ff_q [FIFO_DEPTH];
    logic [SW-1:0]   fs_q [FIFO_DEPTH];
    logic [TAGW-1:0] ft_q [FIFO_DEPTH];

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop        = resp_valid && resp_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fr_q[wr_q[AW-1:0]] <= push_res;
            ff_q[wr_q[AW-1:0]] <= push_flg;
            fs_q[wr_q[AW-1:0]] <= ps_q[LAST];
            ft_q[wr_q[AW-1:0]] <= pt_q[LAST];
        end
    end

    assign resp_valid  = !fifo_empty;
    assign resp_result = resp_valid ? fr_q[rd_q[AW-1:0]] : '0;
    assign resp_flags  = resp_valid ? ff_q[rd_q[AW-1:0]] : '0;
    assign resp_src    = resp_valid ? fs_q[rd_q[AW-1:0]] : '0;
    assign resp_tag    = resp_valid ? ft_q[rd_q[AW-1:0]] : '0;

    // Credits are returned one cycle after the pop since cnt is registered.
    always_comb begin
        cnt_d = cnt_q;
        if (grant) cnt_d = cnt_d + CW'(1);
        if (pop) cnt_d = cnt_d - CW'(1);
        if (flush) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

    always_ff @(posedge clock) begin
        assert (!(push && fifo_full && !pop));
    end

endmodule

// File: tb/tb_fp_cvt_sched.sv
module tb_fp_cvt_sched;
    localparam int unsigned NREQ       = 2;
    localparam int unsigned TAGW       = 4;
    localparam int unsigned RND_LAT    = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                 reset, clock, flush;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [2*NREQ-1:0]    req_kind, req_op, req_fmt;
    logic [65*NREQ-1:0]   req_data;
    logic [3*NREQ-1:0]    req_rm;
    logic [10*NREQ-1:0]   req_class;
    logic [TAGW*NREQ-1:0] req_tag;
    logic [64:0]          cvt_data;
    logic [1:0]           cvt_op, cvt_fmt;
    logic [2:0]           cvt_rm;
    logic [9:0]           cvt_class;
    logic [63:0]          f2i_result, rnd_result, resp_result;
    logic [4:0]           f2i_flags, rnd_flags, resp_flags;
    logic                 rnd_valid, rnd_sel, resp_valid, resp_ready, busy;
    logic [0:0]           resp_src;
    logic [TAGW-1:0]      resp_tag;

    fp_cvt_sched #(.NREQ(NREQ), .TAGW(TAGW), .RND_LAT(RND_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .reset(reset), .clock(clock), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_data(req_data), .req_op(req_op), .req_fmt(req_fmt), .req_rm(req_rm),
        .req_class(req_class), .req_tag(req_tag),
        .cvt_data(cvt_data), .cvt_op(cvt_op), .cvt_fmt(cvt_fmt), .cvt_rm(cvt_rm),
        .cvt_class(cvt_class), .f2i_result(f2i_result), .f2i_flags(f2i_flags),
        .rnd_valid(rnd_valid), .rnd_sel(rnd_sel), .rnd_result(rnd_result),
        .rnd_flags(rnd_flags), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_src(resp_src),
        .resp_tag(resp_tag), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // fp_cvt stub: f2i yields operand+1 with flags from the class bits.
    assign f2i_result = cvt_data[63:0] + 64'd1;
    assign f2i_flags  = cvt_class[4:0];

    // fp_rnd stub: result = operand*16 after RND_LAT cycles; junk when not launched.
    logic [63:0] rs_res [RND_LAT];
    logic [4:0]  rs_flg [RND_LAT];
    always @(posedge clock) begin
        rs_res[0] <= rnd_valid ? {cvt_data[59:0], 4'h0} : 64'hdead_beef_dead_beef;
        rs_flg[0] <= rnd_valid ? ({cvt_op, cvt_rm} ^ {4'b0, rnd_sel}) : 5'h1f;
        for (int s = 1; s < int'(RND_LAT); s++) begin
            rs_res[s] <= rs_res[s-1];
            rs_flg[s] <= rs_flg[s-1];
        end
    end
    assign rnd_result = rs_res[RND_LAT-1];
    assign rnd_flags  = rs_flg[RND_LAT-1];

    typedef struct {
        logic [1:0]      kind;
        logic [64:0]     data;
        logic [1:0]      op;
        logic [1:0]      fmt;
        logic [2:0]      rm;
        logic [9:0]      cls;
        logic [TAGW-1:0] tag;
    } job_t;

    typedef struct {
        logic [63:0]     result;
        logic [4:0]      flags;
        int              src;
        logic [TAGW-1:0] tag;
        int              due;
    } resp_t;

    job_t  jq [NREQ][$];
    resp_t exp_q [$];
    int    nvec, nerr, cyc, last, tagctr;
    bit    prev_rnd;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    function automatic job_t mk(input logic [1:0] kind, input logic [64:0] data,
                                input logic [1:0] op, input logic [2:0] rm,
                                input logic [9:0] cls, input logic [TAGW-1:0] tag);
        job_t j;
        j.kind = kind; j.data = data; j.op = op; j.fmt = 2'd1; j.rm = rm; j.cls = cls; j.tag = tag;
        return j;
    endfunction

    function automatic job_t rand_job();
        job_t j;
        j = mk(2'($urandom_range(0, 3)), {1'($urandom), $urandom, $urandom}, 2'($urandom),
               3'($urandom), 10'($urandom), 4'(tagctr));
        tagctr++;
        return j;
    endfunction

    // Reference result from the conversion rules and the stub definitions.
    function automatic resp_t expect_of(input job_t j, input int src, input int c);
        resp_t r;
        r.src = src; r.tag = j.tag; r.due = c + 2 + int'(RND_LAT);
        case (j.kind)
            2'd0, 2'd2: begin
                r.result = j.data[63:0] << 4;
                r.flags  = {j.op, j.rm} ^ {4'b0, j.kind[1]};
            end
            2'd1: begin
                r.result = j.data[63:0] + 64'd1;
                r.flags  = j.cls[4:0];
            end
            default: begin
                r.result = '0;
                r.flags  = '0;
            end
        endcase
        return r;
    endfunction

    task automatic drive();
        job_t j;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (jq[i].size() > 0) begin
                j = jq[i][0];
                req_valid[i] = 1'b1;
                req_kind[2*i +: 2]       = j.kind;
                req_data[65*i +: 65]     = j.data;
                req_op[2*i +: 2]         = j.op;
                req_fmt[2*i +: 2]        = j.fmt;
                req_rm[3*i +: 3]         = j.rm;
                req_class[10*i +: 10]    = j.cls;
                req_tag[TAGW*i +: TAGW]  = j.tag;
            end else begin
                req_valid[i] = 1'b0;
                req_kind[2*i +: 2]       = 2'($urandom);
                req_data[65*i +: 65]     = {1'b0, $urandom, $urandom};
                req_op[2*i +: 2]         = '0;
                req_fmt[2*i +: 2]        = '0;
                req_rm[3*i +: 3]         = '0;
                req_class[10*i +: 10]    = '0;
                req_tag[TAGW*i +: TAGW]  = '0;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model, redrive after the rise.
    task automatic step();
        logic [NREQ-1:0] rdy_exp;
        bit    g, hv, rnd_exp;
        int    w, idx;
        job_t  j;
        resp_t e;
        @(negedge clock);
        rdy_exp = '0; g = 0; w = 0;
        if (!flush && exp_q.size() < int'(FIFO_DEPTH)) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                idx = (last + k) % int'(NREQ);
                if (!g && jq[idx].size() > 0) begin
                    g = 1; w = idx;
                end
            end
        end
        if (g) rdy_exp[w] = 1'b1;
        rnd_exp = prev_rnd && !flush;
        chk("req_ready", 64'(req_ready), 64'(rdy_exp));
        chk("rnd_valid", 64'(rnd_valid), 64'(rnd_exp));
        chk("busy", 64'(busy), 64'(exp_q.size() != 0));
        hv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        chk("resp_valid", 64'(resp_valid), 64'(hv));
        if (hv) begin
            e = exp_q[0];
            chk("resp_result", resp_result, e.result);
            chk("resp_flags", 64'(resp_flags), 64'(e.flags));
            chk("resp_src", 64'(resp_src), 64'(e.src));
            chk("resp_tag", 64'(resp_tag), 64'(e.tag));
        end
        if (flush) begin
            exp_q.delete();
            prev_rnd = 0;
        end else begin
            if (hv && resp_ready) void'(exp_q.pop_front());
            prev_rnd = 0;
            if (g) begin
                j = jq[w].pop_front();
                exp_q.push_back(expect_of(j, w, cyc));
                last = w;
                prev_rnd = (j.kind == 2'd0) || (j.kind == 2'd2);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        drive();
    endtask

    initial begin
        nvec = 0; nerr = 0; cyc = 0; last = int'(NREQ) - 1; prev_rnd = 0; tagctr = 0;
        reset = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        req_valid = '0; req_kind = '0; req_data = '0; req_op = '0; req_fmt = '0;
        req_rm = '0; req_class = '0; req_tag = '0;

        // Reset state, with a job already offered.
        jq[0].push_back(mk(2'd1, 65'd1, 2'd0, 3'd0, 10'd1, 4'd5));
        drive();
        #3;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rnd_valid", 64'(rnd_valid), 64'd0);
        chk("rst_cvt_data", cvt_data[63:0], 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single f2i: result 0x2, flags 1, src 0, tag 5 four cycles after grant.
        resp_ready = 1'b1;
        repeat (7) step();

        // Two requesters always valid: alternating grants.
        for (int n = 0; n < 4; n++) begin
            jq[0].push_back(rand_job());
            jq[1].push_back(rand_job());
        end
        drive();
        repeat (14) step();

        // Backpressure: 6 jobs offered with no consumer, then drain.
        resp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            jq[0].push_back(rand_job());
            jq[1].push_back(rand_job());
        end
        drive();
        repeat (10) step();
        resp_ready = 1'b1;
        repeat (14) step();

        // Back-to-back f2i, i2f, f2f.
        jq[0].push_back(mk(2'd1, 65'd1, 2'd0, 3'd0, 10'd0, 4'd1));
        jq[0].push_back(mk(2'd2, 65'd2, 2'd1, 3'd2, 10'd0, 4'd2));
        jq[0].push_back(mk(2'd0, 65'd3, 2'd2, 3'd4, 10'd0, 4'd3));
        drive();
        repeat (9) step();

        // Flush with 3 jobs in flight, then a fresh job.
        for (int n = 0; n < 3; n++) jq[1].push_back(rand_job());
        drive();
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        jq[1].push_back(mk(2'd2, 65'h1234, 2'd3, 3'd1, 10'd0, 4'd9));
        drive();
        repeat (7) step();

        // Async reset while the FIFO holds 2 entries.
        resp_ready = 1'b0;
        jq[1].push_back(rand_job());
        jq[1].push_back(rand_job());
        drive();
        repeat (8) step();
        jq[0].push_back(rand_job());
        jq[1].push_back(rand_job());
        drive();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_resp_valid", 64'(resp_valid), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        last = int'(NREQ) - 1;
        prev_rnd = 0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        resp_ready = 1'b1;
        repeat (8) step();

        // Randomized traffic with random backpressure and occasional flush.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(NREQ); i++)
                if (jq[i].size() < 3 && $urandom_range(0, 2) == 0) jq[i].push_back(rand_job());
            resp_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            drive();
            step();
        end
        flush = 1'b0;
        resp_ready = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
